// File: rtl/mem_ctrl_rr.sv
// mem_ctrl_rr: round-robin arbiter plus byte-serial controller that lets
// NUM_PORTS requesters share one byte-wide RAM. It runs one transaction at a
// time. A read collects up to LINE_BYTES bytes into rdata. A write streams
// wdata out byte by byte. A write to either UART word is held off while the
// UART transmit buffer is full.
module mem_ctrl_rr #(
  parameter int                    NUM_PORTS  = 3,
  parameter int                    LINE_BYTES = 16,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(32'h30000),
  localparam int                   LENW       = $clog2(LINE_BYTES),
  localparam int                   DW         = 8 * LINE_BYTES
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            rdy_in,
  input  logic                            io_buffer_full,
  input  logic [7:0]                      mem_din,
  output logic [7:0]                      mem_dout,
  output logic [ADDR_WIDTH-1:0]           mem_a,
  output logic                            mem_wr,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS-1:0]            req_wr,
  input  logic [NUM_PORTS*LENW-1:0]       req_len,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DW-1:0]         req_wdata,
  output logic [DW-1:0]                   rdata,
  output logic [NUM_PORTS-1:0]            done
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [ADDR_WIDTH-1:0] IO_BASE_HI = IO_BASE + ADDR_WIDTH'(4);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t                r_state;
  logic [PW-1:0]         r_ptr;
  logic [PW-1:0]         r_port;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LENW-1:0]       r_len;
  logic [LENW-1:0]       r_cnt;     // next byte to capture (read) or to emit (write)
  logic [DW-1:0]         r_wdata;
  logic [DW-1:0]         r_buf;     // read bytes gathered so far
  logic [DW-1:0]         r_rdata;
  logic [NUM_PORTS-1:0]  r_done;
  logic                  r_issued;  // address of byte r_cnt was driven last cycle
  logic                  r_stall;   // last cycle was frozen by rdy_in=0

  logic [NUM_PORTS-1:0]  w_req_m;
  logic                  w_grant_ok;
  logic [PW-1:0]         w_grant;
  logic [PW-1:0]         w_next_ptr;
  logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_PORTS];
  logic [LENW-1:0]       w_len_arr   [NUM_PORTS];
  logic [DW-1:0]         w_wdata_arr [NUM_PORTS];
  logic                  w_eff_issued;
  logic                  w_issued_view;
  logic [LENW:0]         w_rd_idx;
  logic                  w_addr_valid;
  logic                  w_uart_stall;
  logic [DW-1:0]         w_buf_next;

  assign done  = r_done;
  assign rdata = r_rdata;

  // Unpack the per-port request buses into arrays indexed by port number.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_addr_arr[p]  = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      w_len_arr[p]   = req_len[p*LENW +: LENW];
      w_wdata_arr[p] = req_wdata[p*DW +: DW];
    end
  end

  // Round-robin search: the first unmasked requester at or after r_ptr wins.
  always_comb begin
    logic [PW-1:0] cand;
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it holding an old value (that would infer a latch).
    w_req_m    = req & ~r_done;
    w_grant_ok = 1'b0;
    w_grant    = '0;
    cand       = r_ptr;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_grant_ok && w_req_m[cand]) begin
        w_grant_ok = 1'b1;
        w_grant    = cand;
      end
      cand = (cand == PW'(NUM_PORTS - 1)) ? '0 : cand + 1'b1;
    end
    w_next_ptr = (w_grant == PW'(NUM_PORTS - 1)) ? '0 : w_grant + 1'b1;
  end

  // Read pipeline bookkeeping. Data for an address returns one cycle later. A
  // freeze throws that data away, so the byte is re-addressed on resume. While
  // frozen, the raw flag keeps mem_a steady.
  assign w_eff_issued  = r_issued & ~r_stall;
  assign w_issued_view = rdy_in ? w_eff_issued : r_issued;
  assign w_rd_idx      = {1'b0, r_cnt} + {{LENW{1'b0}}, w_issued_view};
  assign w_addr_valid  = !(w_issued_view && (r_cnt == r_len));
  assign w_uart_stall  = io_buffer_full && ((r_addr == IO_BASE) || (r_addr == IO_BASE_HI));

  // Insert the byte now on mem_din into the read buffer.
  always_comb begin
    w_buf_next = r_buf;
    w_buf_next[{r_cnt, 3'b000} +: 8] = mem_din;
  end

  // Drive the RAM bus from the current state. An idle controller drives zeros.
  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    case (r_state)
      S_READ: begin
        if (w_addr_valid) mem_a = r_addr + ADDR_WIDTH'(w_rd_idx);
      end
      S_WRITE: begin
        mem_a    = r_addr + ADDR_WIDTH'(r_cnt);
        mem_dout = r_wdata[{r_cnt, 3'b000} +: 8];
        mem_wr   = rdy_in & ~w_uart_stall;
      end
      default: ;
    endcase
  end

  // Arbitration, transaction FSM, read capture and completion pulse.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      // NOTE: r_wdata, r_addr and r_len are left out of reset. A grant always
      // reloads them before they are read. r_buf and r_rdata are observable, so
      // they are cleared.
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_port   <= '0;
      r_cnt    <= '0;
      r_buf    <= '0;
      r_rdata  <= '0;
      r_done   <= '0;
      r_issued <= 1'b0;
      r_stall  <= 1'b0;
    end else if (rdy_in) begin
      // NOTE: state updates use non-blocking assignments. Every register then
      // reads the pre-edge value of every other register.
      r_stall <= 1'b0;
      r_done  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_ok) begin
            r_port   <= w_grant;
            r_ptr    <= w_next_ptr;
            r_addr   <= w_addr_arr[w_grant];
            r_len    <= w_len_arr[w_grant];
            r_wdata  <= w_wdata_arr[w_grant];
            r_cnt    <= '0;
            r_buf    <= '0;
            r_issued <= 1'b0;
            r_state  <= req_wr[w_grant] ? S_WRITE : S_READ;
          end
        end
        S_READ: begin
          if (w_eff_issued) begin
            r_buf <= w_buf_next;
            if (r_cnt == r_len) begin
              r_rdata  <= w_buf_next;
              r_done   <= NUM_PORTS'(1) << r_port;
              r_issued <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_cnt    <= r_cnt + 1'b1;
              r_issued <= 1'b1;
            end
          end else begin
            r_issued <= 1'b1;
          end
        end
        S_WRITE: begin
          if (!w_uart_stall) begin
            if (r_cnt == r_len) begin
              r_done  <= NUM_PORTS'(1) << r_port;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end else begin
      r_stall <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_ctrl_rr.sv
// tb_mem_ctrl_rr: self-checking bench for mem_ctrl_rr with a behavioural RAM
// on the bus, a table of directed transactions, hand-written stall, freeze,
// reset and round-robin sequences, and randomized traffic from three ports.
// Random traffic is checked against a byte-array memory model.
module tb_mem_ctrl_rr;

  localparam int NP   = 3;
  localparam int LB   = 16;
  localparam int AW   = 32;
  localparam int LENW = 4;
  localparam int DW   = 128;
  localparam int BUDGET = 300;
  localparam int N_RAND = 20;

  logic              clk;
  logic              rst_in;
  logic              rdy_in;
  logic              io_buffer_full;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [AW-1:0]     mem_a;
  logic              mem_wr;
  logic [NP-1:0]     req;
  logic [NP-1:0]     req_wr;
  logic [NP*LENW-1:0] req_len;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*DW-1:0]  req_wdata;
  logic [DW-1:0]     rdata;
  logic [NP-1:0]     done;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  mem_ctrl_rr #(.NUM_PORTS(NP), .LINE_BYTES(LB), .ADDR_WIDTH(AW), .IO_BASE(32'h30000)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .req(req), .req_wr(req_wr), .req_len(req_len), .req_addr(req_addr),
    .req_wdata(req_wdata), .rdata(rdata), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM on the bus: synchronous byte read; unwritten bytes hold addr[7:0].
  logic [7:0] ram [logic [31:0]];
  // Expected memory contents, maintained from the transactions the bench issues.
  logic [7:0] exp_mem [logic [31:0]];

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : a[7:0];
  endfunction

  function automatic logic [7:0] exp_rd(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : a[7:0];
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [31:0] a, input int len);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k <= len; k++) r[8*k +: 8] = exp_rd(a + 32'(k));
    return r;
  endfunction

  task automatic model_write(input logic [31:0] a, input int len, input logic [DW-1:0] wd);
    for (int k = 0; k <= len; k++) exp_mem[a + 32'(k)] = wd[8*k +: 8];
  endtask

  always @(posedge clk) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= ram_rd(mem_a);
  end

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Invariants every cycle: at most one done bit, never done together with a write.
  always @(negedge clk) begin
    if (!rst_in) begin
      check("done_onehot", DW'($onehot0(done)), DW'(1));
      check("done_with_wr", DW'((done != '0) && mem_wr), DW'(0));
      if (|done) n_done++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input bit wr, input int len, input logic [31:0] a,
                          input logic [DW-1:0] wd);
    req_wr[p]               = wr;
    req_len[p*LENW +: LENW] = len[LENW-1:0];
    req_addr[p*AW +: AW]    = a;
    req_wdata[p*DW +: DW]   = wd;
  endtask

  // Issue one transaction from an idle controller. Latency is counted from the
  // grant cycle (the cycle req rises) to the done pulse; -1 means it timed out.
  task automatic run_txn(input int p, input bit wr, input int len, input logic [31:0] a,
                         input logic [DW-1:0] wd, output int lat, output int nwr,
                         output logic [AW-1:0] first_a, output logic [DW-1:0] rd);
    set_port(p, wr, len, a, wd);
    req[p]  = 1'b1;
    lat     = -1;
    nwr     = 0;
    first_a = '0;
    rd      = '0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      if (mem_wr) nwr++;
      if (c == 1) first_a = mem_a;
      if (done[p]) begin
        lat = c;
        rd  = rdata;
        break;
      end
      tick();
    end
    tick();
    req[p] = 1'b0;
  endtask

  typedef struct {
    int             port;
    bit             wr;
    int             len;
    logic [31:0]    addr;
    logic [DW-1:0]  wd;
    bit             full;
    int             exp_lat;
    logic [DW-1:0]  exp_rd;
  } vec_t;

  vec_t tbl[9];

  // One randomized requester: random gaps, random read/write in a small window.
  task automatic port_proc(input int p);
    bit            wr;
    int            len;
    int            snap;
    bit            got;
    logic [31:0]   a;
    logic [DW-1:0] wd;
    for (int t = 0; t < N_RAND; t++) begin
      repeat ($urandom_range(1, 4)) tick();
      wr  = 1'($urandom_range(0, 1));
      len = $urandom_range(0, LB - 1);
      a   = 32'h4000 + 32'($urandom_range(0, 63));
      wd  = {$urandom, $urandom, $urandom, $urandom};
      set_port(p, wr, len, a, wd);
      snap   = n_done;
      req[p] = 1'b1;
      got    = 1'b0;
      for (int c = 0; c < BUDGET; c++) begin
        @(negedge clk);
        if (done[p]) begin
          got = 1'b1;
          break;
        end
        tick();
      end
      check($sformatf("rand_p%0d_done", p), DW'(got), DW'(1));
      if (got) begin
        if (wr) model_write(a, len, wd);
        else    check($sformatf("rand_p%0d_rdata", p), rdata, model_read(a, len));
      end
      tick();
      req[p] = 1'b0;
      // No other requester may be served more than NP-1 times while this one waits.
      if (got) check($sformatf("rand_p%0d_fair", p), DW'((n_done - snap - 1) <= NP - 1), DW'(1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int            lat;
    int            nwr;
    int            nd;
    int            bad;
    int            order[6];
    logic [AW-1:0] fa;
    logic [DW-1:0] rd;
    logic [NP-1:0] drop;
    logic [DW-1:0] k_pat;

    k_pat = 128'h00112233445566778899AABBCCDDEEFF;
    //        port wr len addr          wdata            full lat  expected rdata
    tbl[0] = '{0, 0, 15, 32'h0000_1000, '0,               0, 18, 128'h0F0E0D0C0B0A09080706050403020100};
    tbl[1] = '{1, 1,  3, 32'h0000_2000, 128'hDEADBEEF,    0,  5, 128'h0F0E0D0C0B0A09080706050403020100};
    tbl[2] = '{2, 0,  3, 32'h0000_2000, '0,               0,  6, 128'hDEADBEEF};
    tbl[3] = '{0, 0,  3, 32'hFFFF_FFFE, '0,               0,  6, 128'h0100FFFE};
    tbl[4] = '{1, 1,  0, 32'h0003_0008, 128'hA5,          1,  2, 128'h0100FFFE};
    tbl[5] = '{2, 0,  0, 32'h0003_0008, '0,               0,  3, 128'hA5};
    tbl[6] = '{0, 1, 15, 32'hFFFF_FFF8, k_pat,            0, 17, 128'hA5};
    tbl[7] = '{1, 0, 15, 32'hFFFF_FFF8, '0,               0, 18, k_pat};
    tbl[8] = '{2, 0,  0, 32'h0000_0010, '0,               0,  3, 128'h10};

    rst_in = 1'b1; rdy_in = 1'b0; io_buffer_full = 1'b0;
    req = '0; req_wr = '0; req_len = '0; req_addr = '0; req_wdata = '0;

    // Reset applies even while rdy_in is low.
    repeat (3) tick();
    @(negedge clk);
    check("rst_done",  DW'(done),     DW'(0));
    check("rst_wr",    DW'(mem_wr),   DW'(0));
    check("rst_a",     DW'(mem_a),    DW'(0));
    check("rst_dout",  DW'(mem_dout), DW'(0));
    check("rst_rdata", rdata,         DW'(0));
    tick();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    tick();

    // Directed transaction table.
    for (int i = 0; i < 9; i++) begin
      io_buffer_full = tbl[i].full;
      run_txn(tbl[i].port, tbl[i].wr, tbl[i].len, tbl[i].addr, tbl[i].wd, lat, nwr, fa, rd);
      io_buffer_full = 1'b0;
      if (tbl[i].wr) model_write(tbl[i].addr, tbl[i].len, tbl[i].wd);
      check($sformatf("vec%0d_latency", i), DW'(lat), DW'(tbl[i].exp_lat));
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("vec%0d_first_addr", i), DW'(fa), DW'(tbl[i].addr));
      check($sformatf("vec%0d_write_cycles", i), DW'(nwr), DW'(tbl[i].wr ? tbl[i].len + 1 : 0));
    end
    check("wr_2000", DW'(ram_rd(32'h2000)), DW'(8'hEF));
    check("wr_2001", DW'(ram_rd(32'h2001)), DW'(8'hBE));
    check("wr_2002", DW'(ram_rd(32'h2002)), DW'(8'hAD));
    check("wr_2003", DW'(ram_rd(32'h2003)), DW'(8'hDE));

    // UART stall: write to IO_BASE waits while the buffer is full.
    io_buffer_full = 1'b1;
    set_port(2, 1'b1, 0, 32'h0003_0000, 128'h5A);
    req[2] = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      @(negedge clk);
      check($sformatf("uart_stall_c%0d", c), DW'(mem_wr), DW'(0));
    end
    tick();
    io_buffer_full = 1'b0;
    @(negedge clk);
    check("uart_resume_wr",   DW'(mem_wr),   DW'(1));
    check("uart_resume_a",    DW'(mem_a),    DW'(32'h0003_0000));
    check("uart_resume_dout", DW'(mem_dout), DW'(8'h5A));
    tick();
    @(negedge clk);
    check("uart_done", DW'(done), DW'(3'b100));
    tick();
    req[2] = 1'b0;
    tick();

    // Freeze for three cycles in mid-read: one extra cycle to re-address.
    set_port(0, 1'b0, 7, 32'h0000_1000, '0);
    req[0] = 1'b1;
    lat = -1;
    repeat (3) tick();
    rdy_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("freeze_wr",   DW'(mem_wr), DW'(0));
      check("freeze_done", DW'(done),   DW'(0));
      tick();
    end
    rdy_in = 1'b1;
    for (int c = 6; c < BUDGET; c++) begin
      @(negedge clk);
      if (done[0]) begin
        lat = c;
        break;
      end
      tick();
    end
    check("freeze_latency", DW'(lat), DW'(14));
    check("freeze_rdata", rdata, model_read(32'h0000_1000, 7));
    tick();
    req[0] = 1'b0;
    tick();

    // Reset during a write: three bytes land, then nothing more and no done.
    set_port(1, 1'b1, 7, 32'h0000_5000, 128'hF1F2F3F4F5F6F7F8);
    req[1] = 1'b1;
    repeat (3) tick();
    rst_in = 1'b1;
    req[1] = 1'b0;
    tick();
    rst_in = 1'b0;
    @(negedge clk);
    check("midrst_done",  DW'(done),   DW'(0));
    check("midrst_wr",    DW'(mem_wr), DW'(0));
    check("midrst_rdata", rdata,       DW'(0));
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge clk);
      if (done != '0 || mem_wr) bad++;
    end
    check("midrst_quiet", DW'(bad), DW'(0));
    check("midrst_byte2", DW'(ram_rd(32'h5002)), DW'(8'hF6));
    check("midrst_byte3", DW'(ram_rd(32'h5003)), DW'(8'h03));
    tick();

    // Round-robin with all ports requesting; the pointer restarts at port 0.
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, 0, 32'h100 + 32'(p), '0);
    req = '1;
    nd  = 0;
    for (int c = 0; c < BUDGET && nd < 6; c++) begin
      @(negedge clk);
      drop = done;
      for (int p = 0; p < NP; p++) if (done[p]) begin
        order[nd] = p;
        nd++;
      end
      tick();
      req = (nd < 6) ? ~drop : '0;
    end
    req = '0;
    check("rr_count", DW'(nd), DW'(6));
    for (int i = 0; i < 6; i++)
      check($sformatf("rr_grant%0d", i), DW'(order[i]), DW'(i % NP));
    repeat (8) tick();

    // Randomized traffic from all ports at once.
    fork
      port_proc(0);
      port_proc(1);
      port_proc(2);
    join
    repeat (4) tick();

    bad = 0;
    for (int k = 0; k < 96; k++)
      if (ram_rd(32'h4000 + 32'(k)) !== exp_rd(32'h4000 + 32'(k))) bad++;
    check("ram_sweep", DW'(bad), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
